// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: word load/store over a req/ready data bus, alignment check, MEM register
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int REG_W = 5,
  parameter int EXP_W = 3,
  parameter logic [EXP_W-1:0] EXP_NONE = 3'd0,
  parameter logic [EXP_W-1:0] EXP_MISALIGN = 3'd4
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              IntDetect,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] EXPC,
  input  logic              EXEn,
  input  logic [1:0]        EXMemOp,
  input  logic [DATA_W-1:0] EXMemWrData,
  input  logic [1:0]        EXCtrlOp,
  input  logic [REG_W-1:0]  EXDstAddr,
  input  logic              EXGPRWE_,
  input  logic [EXP_W-1:0]  EXExpCode,
  input  logic [DATA_W-1:0] EXOut,
  output logic              BusReq,
  output logic              BusRW,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusWrData,
  input  logic [DATA_W-1:0] BusRdData,
  input  logic              BusRdy,
  output logic              MemBusy,
  output logic [ADDR_W-1:0] MEMPC,
  output logic              MEMEn,
  output logic [1:0]        MEMCtrlOp,
  output logic [REG_W-1:0]  MEMDstAddr,
  output logic              MEMGPRWE_,
  output logic [EXP_W-1:0]  MEMExpCode,
  output logic [DATA_W-1:0] MEMOut
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              en;
    logic [1:0]        ctrl;
    logic [REG_W-1:0]  dst;
    logic              gprwe_n;
    logic [EXP_W-1:0]  exp;
    logic [DATA_W-1:0] out;
  } mem_reg_t;

  localparam logic [1:0] OP_LW = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;
  localparam mem_reg_t MEM_BUBBLE = '{pc: '0, en: 1'b0, ctrl: 2'b00, dst: '0,
                                      gprwe_n: 1'b1, exp: EXP_NONE, out: '0};

  state_t            state_q, state_d;
  mem_reg_t          mem_q, mem_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              req_rw_q, req_rw_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic is_mem, chk_ok, misalign, want, kill, cap_req;
  logic bus_req_st, do_bubble, do_load, use_bus_data, use_hold_data, capture_hold;
  logic [EXP_W-1:0] exp_sel;

  assign is_mem   = (EXMemOp == OP_LW) || (EXMemOp == OP_SW);
  assign chk_ok   = EXEn && is_mem && (EXExpCode == EXP_NONE);
  assign misalign = chk_ok && (EXOut[1:0] != 2'b00);
  assign want     = chk_ok && (EXOut[1:0] == 2'b00) && !IntDetect && !Flush;
  assign kill     = Flush || IntDetect;
  assign cap_req  = (state_q == S_IDLE) && want;

  // Request fields are latched at issue so they stay put even if EX is flushed mid-transfer.
  assign BusReq    = bus_req_st && !reset_;
  assign BusRW     = (state_q == S_IDLE) ? (EXMemOp == OP_LW) : req_rw_q;
  assign BusAddr   = (state_q == S_IDLE) ? EXOut[ADDR_W+1:2] : req_addr_q;
  assign BusWrData = (state_q == S_IDLE) ? EXMemWrData : req_wdata_q;
  assign MemBusy   = BusReq && !BusRdy;

  always_ff @(posedge clk) begin
    if (reset_) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (want) state_d = BusRdy ? (Stall ? S_DONE : S_IDLE) : S_WAIT;
      S_WAIT: begin
        if (BusRdy)    state_d = (Stall && !kill) ? S_DONE : S_IDLE;
        else if (kill) state_d = S_DRAIN;
      end
      S_DONE:  if (kill || !Stall) state_d = S_IDLE;
      S_DRAIN: if (BusRdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_st    = 1'b0;
    do_bubble     = 1'b0;
    do_load       = 1'b0;
    use_bus_data  = 1'b0;
    use_hold_data = 1'b0;
    capture_hold  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus_req_st = want;
        if (kill) do_bubble = 1'b1;
        else if (!(want && !BusRdy)) begin
          if (!Stall) begin
            do_load      = 1'b1;
            use_bus_data = want && (EXMemOp == OP_LW);
          end else begin
            capture_hold = want;
          end
        end
      end
      S_WAIT: begin
        bus_req_st = 1'b1;
        if (kill) do_bubble = 1'b1;
        else if (BusRdy) begin
          if (!Stall) begin
            do_load      = 1'b1;
            use_bus_data = req_rw_q;
          end else begin
            capture_hold = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (kill) do_bubble = 1'b1;
        else if (!Stall) begin
          do_load       = 1'b1;
          use_hold_data = req_rw_q;
        end
      end
      S_DRAIN: begin
        bus_req_st = 1'b1;
        do_bubble  = BusRdy || kill;
      end
      default: do_bubble = 1'b1;
    endcase
  end

  assign exp_sel = misalign ? EXP_MISALIGN : EXExpCode;

  always_comb begin
    mem_d = mem_q;
    if (do_bubble) begin
      mem_d = MEM_BUBBLE;
    end else if (do_load) begin
      mem_d.pc      = EXPC;
      mem_d.en      = EXEn;
      mem_d.ctrl    = EXCtrlOp;
      mem_d.dst     = EXDstAddr;
      mem_d.exp     = exp_sel;
      mem_d.gprwe_n = (exp_sel != EXP_NONE) ? 1'b1 : EXGPRWE_;
      mem_d.out     = use_bus_data ? BusRdData : (use_hold_data ? hold_q : EXOut);
    end
  end

  assign hold_d      = capture_hold ? BusRdData : hold_q;
  assign req_rw_d    = cap_req ? (EXMemOp == OP_LW) : req_rw_q;
  assign req_addr_d  = cap_req ? EXOut[ADDR_W+1:2] : req_addr_q;
  assign req_wdata_d = cap_req ? EXMemWrData : req_wdata_q;

  always_ff @(posedge clk) begin
    if (reset_) begin
      mem_q       <= MEM_BUBBLE;
      hold_q      <= '0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      mem_q       <= mem_d;
      hold_q      <= hold_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  assign MEMPC      = mem_q.pc;
  assign MEMEn      = mem_q.en;
  assign MEMCtrlOp  = mem_q.ctrl;
  assign MEMDstAddr = mem_q.dst;
  assign MEMGPRWE_  = mem_q.gprwe_n;
  assign MEMExpCode = mem_q.exp;
  assign MEMOut     = mem_q.out;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_, IntDetect, Stall, Flush, ext_stall;
  logic [29:0] EXPC;
  logic        EXEn;
  logic [1:0]  EXMemOp;
  logic [31:0] EXMemWrData;
  logic [1:0]  EXCtrlOp;
  logic [4:0]  EXDstAddr;
  logic        EXGPRWE_;
  logic [2:0]  EXExpCode;
  logic [31:0] EXOut;
  logic        BusReq, BusRW;
  logic [29:0] BusAddr;
  logic [31:0] BusWrData, BusRdData;
  logic        BusRdy, MemBusy;
  logic [29:0] MEMPC;
  logic        MEMEn;
  logic [1:0]  MEMCtrlOp;
  logic [4:0]  MEMDstAddr;
  logic        MEMGPRWE_;
  logic [2:0]  MEMExpCode;
  logic [31:0] MEMOut;

  mem_stage dut (
    .clk(clk), .reset_(reset_), .IntDetect(IntDetect), .Stall(Stall), .Flush(Flush),
    .EXPC(EXPC), .EXEn(EXEn), .EXMemOp(EXMemOp), .EXMemWrData(EXMemWrData),
    .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr), .EXGPRWE_(EXGPRWE_),
    .EXExpCode(EXExpCode), .EXOut(EXOut), .BusReq(BusReq), .BusRW(BusRW),
    .BusAddr(BusAddr), .BusWrData(BusWrData), .BusRdData(BusRdData), .BusRdy(BusRdy),
    .MemBusy(MemBusy), .MEMPC(MEMPC), .MEMEn(MEMEn), .MEMCtrlOp(MEMCtrlOp),
    .MEMDstAddr(MEMDstAddr), .MEMGPRWE_(MEMGPRWE_), .MEMExpCode(MEMExpCode),
    .MEMOut(MEMOut)
  );

  // The pipeline controller folds MemBusy into Stall.
  assign Stall = ext_stall | MemBusy;

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] pc;
    logic        en;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        gwe_n;
    logic [2:0]  exp;
    logic [31:0] out;
  } instr_t;

  typedef struct {
    logic [29:0] pc;
    logic        en;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        gwe_n;
    logic [2:0]  exp;
    logic [31:0] out;
  } mem_t;

  int     checks = 0;
  int     errors = 0;
  mem_t   last;
  mem_t   bubble;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_memop(instr_t i);
    return i.en && (i.op == 2'd1 || i.op == 2'd2) && i.exp == 3'd0;
  endfunction

  function automatic bit is_access(instr_t i);
    return is_memop(i) && i.out[1:0] == 2'b00;
  endfunction

  function automatic mem_t expect_mem(instr_t i, logic [31:0] rd);
    mem_t r;
    r.pc    = i.pc;
    r.en    = i.en;
    r.ctrl  = i.ctrl;
    r.dst   = i.dst;
    r.exp   = (is_memop(i) && i.out[1:0] != 2'b00) ? 3'd4 : i.exp;
    r.gwe_n = (r.exp != 3'd0) ? 1'b1 : i.gwe_n;
    r.out   = (is_access(i) && i.op == 2'd1) ? rd : i.out;
    return r;
  endfunction

  task automatic apply_ex(input instr_t i);
    EXPC = i.pc; EXEn = i.en; EXMemOp = i.op; EXMemWrData = i.wd;
    EXCtrlOp = i.ctrl; EXDstAddr = i.dst; EXGPRWE_ = i.gwe_n;
    EXExpCode = i.exp; EXOut = i.out;
  endtask

  task automatic check_mem(input string tag, input mem_t e);
    chk({tag, ".out"},  64'(MEMOut), 64'(e.out));
    chk({tag, ".en"},   64'(MEMEn), 64'(e.en));
    chk({tag, ".exp"},  64'(MEMExpCode), 64'(e.exp));
    chk({tag, ".gwe"},  64'(MEMGPRWE_), 64'(e.gwe_n));
    chk({tag, ".pc"},   64'(MEMPC), 64'(e.pc));
    chk({tag, ".dst"},  64'(MEMDstAddr), 64'(e.dst));
    chk({tag, ".ctrl"}, 64'(MEMCtrlOp), 64'(e.ctrl));
  endtask

  function automatic instr_t mk(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    instr_t i;
    i.pc = 30'h123; i.en = 1'b1; i.op = op; i.wd = wd; i.ctrl = 2'd1;
    i.dst = 5'd7; i.gwe_n = (op == 2'd2); i.exp = 3'd0; i.out = addr;
    return i;
  endfunction

  // nw wait cycles, then ns external-stall cycles starting at completion, then one free cycle.
  task automatic run_instr(input string tag, input instr_t i, input int nw, input int ns,
                           input logic [31:0] rd);
    bit   acc;
    int   w, total;
    mem_t e;
    acc   = is_access(i);
    w     = acc ? nw : 0;
    total = w + ns + 1;
    e     = expect_mem(i, rd);
    apply_ex(i);
    for (int c = 0; c < total; c++) begin
      ext_stall = (c >= w) && (c < w + ns);
      BusRdy    = acc && (c == w);
      BusRdData = (c == w) ? rd : $urandom;
      @(negedge clk);
      chk({tag, ".req"},  64'(BusReq), 64'(acc && c <= w));
      chk({tag, ".busy"}, 64'(MemBusy), 64'(acc && c < w));
      chk({tag, ".hold"}, 64'(MEMOut), 64'(last.out));
      if (acc && c <= w) begin
        chk({tag, ".addr"}, 64'(BusAddr), 64'(i.out[31:2]));
        chk({tag, ".rw"},   64'(BusRW), 64'(i.op == 2'd1));
        if (i.op == 2'd2) chk({tag, ".wdata"}, 64'(BusWrData), 64'(i.wd));
      end
      @(posedge clk); #1;
    end
    ext_stall = 1'b0;
    BusRdy    = 1'b0;
    check_mem(tag, e);
    last = e;
  endtask

  initial begin
    instr_t i;
    bubble = '{pc: 30'd0, en: 1'b0, ctrl: 2'd0, dst: 5'd0, gwe_n: 1'b1, exp: 3'd0, out: 32'd0};
    reset_ = 1'b1; IntDetect = 1'b0; Flush = 1'b0; ext_stall = 1'b0;
    BusRdy = 1'b0; BusRdData = '0;
    i = mk(2'd0, 32'd0, 32'd0);
    i.en = 1'b0;
    apply_ex(i);
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b0;
    @(negedge clk);
    chk("rst.req", 64'(BusReq), 64'(0));
    chk("rst.busy", 64'(MemBusy), 64'(0));
    check_mem("rst", bubble);
    @(posedge clk); #1;
    last = bubble;

    run_instr("zw_load", mk(2'd1, 32'h100, 32'h0), 0, 0, 32'hDEADBEEF);
    run_instr("st_wait2", mk(2'd2, 32'h200, 32'h12345678), 2, 0, 32'hFFFF0000);
    run_instr("misalign", mk(2'd1, 32'h102, 32'h0), 0, 0, 32'h0);
    run_instr("ext_stall", mk(2'd1, 32'h104, 32'h0), 0, 3, 32'hA5A5A5A5);
    run_instr("wait_stall", mk(2'd1, 32'h108, 32'h0), 2, 2, 32'h5A5A1234);
    run_instr("alu_op", mk(2'd0, 32'hCAFE0001, 32'h0), 0, 1, 32'h0);

    // Flush while a load waits: transfer is drained, a bubble is loaded.
    i = mk(2'd1, 32'h300, 32'h0);
    apply_ex(i);
    for (int c = 0; c < 5; c++) begin
      Flush  = (c == 1);
      if (c >= 2) EXEn = 1'b0;
      BusRdy = (c == 4);
      BusRdData = 32'h77777777;
      @(negedge clk);
      chk("flush.req", 64'(BusReq), 64'(1));
      chk("flush.busy", 64'(MemBusy), 64'(c < 4));
      chk("flush.addr", 64'(BusAddr), 64'(30'hC0));
      @(posedge clk); #1;
    end
    Flush = 1'b0; BusRdy = 1'b0;
    check_mem("flush", bubble);
    last = bubble;

    // Interrupt suppresses a wanted access.
    run_instr("pre_int", mk(2'd0, 32'h44, 32'h0), 0, 0, 32'h0);
    apply_ex(mk(2'd1, 32'h400, 32'h0));
    IntDetect = 1'b1;
    @(negedge clk);
    chk("int.req", 64'(BusReq), 64'(0));
    @(posedge clk); #1;
    IntDetect = 1'b0;
    check_mem("int", bubble);
    last = bubble;

    for (int n = 0; n < 300; n++) begin
      i.pc    = 30'($urandom);
      i.en    = ($urandom_range(0, 7) != 0);
      i.op    = 2'($urandom_range(0, 3));
      i.wd    = $urandom;
      i.ctrl  = 2'($urandom_range(0, 3));
      i.dst   = 5'($urandom_range(0, 31));
      i.gwe_n = 1'($urandom_range(0, 1));
      i.exp   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      i.out   = $urandom;
      if ($urandom_range(0, 3) != 0) i.out[1:0] = 2'b00;
      run_instr("rand", i, $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0, $urandom);
    end

    // Reset during WAIT: bus request drops at once and the stage returns to idle.
    run_instr("pre_rst", mk(2'd0, 32'h88, 32'h0), 0, 0, 32'h0);
    apply_ex(mk(2'd1, 32'h500, 32'h0));
    BusRdy = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    EXEn = 1'b0;
    @(negedge clk);
    chk("midrst.req_now", 64'(BusReq), 64'(0));
    @(posedge clk); #1;
    reset_ = 1'b0;
    chk("midrst.req", 64'(BusReq), 64'(0));
    chk("midrst.busy", 64'(MemBusy), 64'(0));
    chk("midrst.en", 64'(MEMEn), 64'(0));
    chk("midrst.gwe", 64'(MEMGPRWE_), 64'(1));
    @(negedge clk);
    chk("midrst.idle_req", 64'(BusReq), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
